// File: rtl/f2s_pkg.sv
// Shared types and width helpers for the fast-to-slow pulse scheduler.
// No logic of its own; elaboration-time helpers only.
package f2s_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2,
        ST_GAP     = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Width able to index n items, never narrower than one bit.
    function automatic int id_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/f2s_rr_arbiter.sv
// Round-robin pick among non-empty requesters, searching upward from ptr with wrap.
// Purely combinational, zero latency; no backpressure of its own.
module f2s_rr_arbiter
    import f2s_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id
);

    int idx;

    // Walk offsets from the farthest back to ptr so the nearest hit wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        idx         = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (req[idx]) begin
                grant_valid = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/f2s_pulse_scheduler.sv
// Counts per-requester pulses and serialises them onto one 4-phase req/ack channel, round-robin.
// Pulse to xfer_req is two edges when idle; the channel is held until xfer_ack returns, events queue meanwhile.
module f2s_pulse_scheduler
    import f2s_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int CNT_W    = 3,
    parameter int MIN_HOLD = 2,
    parameter int GAP      = 2,
    parameter int ID_W     = id_width(NUM_REQ)
) (
    input  logic               clk1,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] pulse_in,
    input  logic               xfer_ack,
    input  logic               clr_overflow,
    output logic               xfer_req,
    output logic [ID_W-1:0]    xfer_id,
    output logic               pending_any,
    output logic [NUM_REQ-1:0] overflow,
    output logic               busy
);

    localparam int HOLD_W = id_width(MIN_HOLD + 1);
    localparam int GAP_W  = id_width(GAP + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t             state;
    logic [CNT_W-1:0]   cnt [NUM_REQ];
    logic [ID_W-1:0]    rr_ptr;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [GAP_W-1:0]   gap_cnt;

    logic [NUM_REQ-1:0] req_vec;
    logic [NUM_REQ-1:0] granted;
    logic [NUM_REQ-1:0] ovf_set;
    logic               grant_valid;
    logic [ID_W-1:0]    grant_id;
    logic               grant;

    f2s_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req         (req_vec),
        .ptr         (rr_ptr),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign grant       = (state == ST_IDLE) && grant_valid;
    assign pending_any = |req_vec;
    assign busy        = (state != ST_IDLE);

    always_comb begin
        req_vec = '0;
        granted = '0;
        ovf_set = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_vec[i] = (cnt[i] != '0);
            granted[i] = grant && (grant_id == ID_W'(i));
            ovf_set[i] = pulse_in[i] && !granted[i] && (cnt[i] == CNT_MAX);
        end
    end

    // A pulse and a grant in the same cycle cancel, so the counter holds.
    always_ff @(posedge clk1 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt[i] <= '0;
            end
            overflow <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (pulse_in[i] && !granted[i]) begin
                    if (cnt[i] != CNT_MAX) begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else if (granted[i] && !pulse_in[i]) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
            overflow <= (overflow & ~{NUM_REQ{clr_overflow}}) | ovf_set;
        end
    end

    always_ff @(posedge clk1 or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            xfer_req <= 1'b0;
            xfer_id  <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        state    <= ST_REQ;
                        xfer_req <= 1'b1;
                        xfer_id  <= grant_id;
                        hold_cnt <= HOLD_W'(1);
                        rr_ptr   <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                    end
                end
                ST_REQ: begin
                    // An ack that is already high still has to wait out the hold time.
                    if ((hold_cnt >= HOLD_W'(MIN_HOLD)) && xfer_ack) begin
                        state    <= ST_RELEASE;
                        xfer_req <= 1'b0;
                    end else if (hold_cnt < HOLD_W'(MIN_HOLD)) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (!xfer_ack) begin
                        if (GAP == 0) begin
                            state <= ST_IDLE;
                        end else begin
                            state   <= ST_GAP;
                            gap_cnt <= GAP_W'(GAP);
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt <= GAP_W'(1)) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    xfer_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_f2s_pulse_scheduler.sv
// Self-checking bench for f2s_pulse_scheduler: table vectors, corner sequences, randomized traffic vs. a count-level model.
module tb_f2s_pulse_scheduler;

    localparam int N        = 4;
    localparam int CNT_W    = 3;
    localparam int MIN_HOLD = 2;
    localparam int GAP      = 2;
    localparam int ID_W     = 2;
    localparam int CMAX     = (1 << CNT_W) - 1;

    logic            clk1 = 1'b0;
    logic            reset_n;
    logic [N-1:0]    pulse_in;
    logic            xfer_ack;
    logic            clr_overflow;
    logic            xfer_req;
    logic [ID_W-1:0] xfer_id;
    logic            pending_any;
    logic [N-1:0]    overflow;
    logic            busy;

    always #5 clk1 = ~clk1;

    f2s_pulse_scheduler #(
        .NUM_REQ  (N),
        .CNT_W    (CNT_W),
        .MIN_HOLD (MIN_HOLD),
        .GAP      (GAP),
        .ID_W     (ID_W)
    ) dut (
        .clk1         (clk1),
        .reset_n      (reset_n),
        .pulse_in     (pulse_in),
        .xfer_ack     (xfer_ack),
        .clr_overflow (clr_overflow),
        .xfer_req     (xfer_req),
        .xfer_id      (xfer_id),
        .pending_any  (pending_any),
        .overflow     (overflow),
        .busy         (busy)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: pending event counts, sticky overflow, round-robin pointer.
    int        m_cnt [N];
    logic [N-1:0] m_ovf;
    int        m_ptr;
    int        cur_id;
    logic      prev_req;
    int        req_len;
    int        rises;
    int        id_log[$];

    bit        auto_ack;
    int        ack_cnt;
    bit        rand_ack;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick();
        for (int k = 0; k < N; k++) begin
            if (m_cnt[(m_ptr + k) % N] > 0) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic int count_id(input int from, input int id);
        int n = 0;
        for (int k = from; k < id_log.size(); k++) begin
            if (id_log[k] == id) n++;
        end
        return n;
    endfunction

    task automatic model_init();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_ovf    = '0;
        m_ptr    = 0;
        cur_id   = 0;
        prev_req = 1'b0;
        req_len  = 0;
    endtask

    // One clock: apply the inputs set by the caller, update model, check, clear one-cycle inputs.
    task automatic tick();
        int   k;
        logic a_edge;
        bit   any;
        a_edge = xfer_ack;
        @(posedge clk1);
        #1;
        if (xfer_req && !prev_req) begin
            rises++;
            k = rr_pick();
            chk("grant_with_pending", 32'(k >= 0), 32'd1);
            if (k >= 0) begin
                chk("grant_id", 32'(xfer_id), 32'(k));
                cur_id = k;
                m_cnt[k]--;
                m_ptr = (k + 1) % N;
            end
            id_log.push_back(int'(xfer_id));
            req_len = 0;
        end
        if (!xfer_req && prev_req) begin
            chk("req_min_hold", 32'(req_len >= MIN_HOLD), 32'd1);
            chk("req_fall_after_ack", 32'(a_edge), 32'd1);
        end
        if (xfer_req) begin
            req_len++;
            chk("id_stable", 32'(xfer_id), 32'(cur_id));
        end
        if (clr_overflow) m_ovf = '0;
        for (int i = 0; i < N; i++) begin
            if (pulse_in[i]) begin
                if (m_cnt[i] == CMAX) m_ovf[i] = 1'b1;
                else m_cnt[i]++;
            end
        end
        any = 1'b0;
        for (int i = 0; i < N; i++) if (m_cnt[i] > 0) any = 1'b1;
        chk("pending_any", 32'(pending_any), 32'(any));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        prev_req     = xfer_req;
        pulse_in     = '0;
        clr_overflow = 1'b0;
        if (auto_ack && (xfer_ack != xfer_req)) begin
            if (ack_cnt == 0) begin
                xfer_ack = xfer_req;
                ack_cnt  = rand_ack ? int'($urandom_range(3)) : 0;
            end else begin
                ack_cnt--;
            end
        end
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        pulse_in     = '0;
        xfer_ack     = 1'b0;
        clr_overflow = 1'b0;
        ack_cnt      = 0;
        repeat (3) @(posedge clk1);
        #1;
        chk("rst_req", 32'(xfer_req), 32'd0);
        chk("rst_id", 32'(xfer_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pending", 32'(pending_any), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        reset_n = 1'b1;
        model_init();
    endtask

    task automatic drain(input int budget);
        int c = 0;
        auto_ack = 1'b1;
        while ((busy || pending_any || xfer_ack) && c < budget) begin
            tick();
            c++;
        end
        chk("drain_within_budget", 32'(c < budget), 32'd1);
    endtask

    typedef struct {
        logic [N-1:0]    pulse;
        logic            ack;
        logic            clr;
        logic            exp_req;
        logic [ID_W-1:0] exp_id;
        logic            exp_busy;
        logic            exp_pend;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int n0;
        // Single event, ack raised on the third REQ cycle, GAP=2 idle cycles before busy drops.
        tbl[0] = '{4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1};
        tbl[1] = '{4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0};
        tbl[2] = '{4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0};
        tbl[3] = '{4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0};
        tbl[4] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0};
        tbl[5] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0};
        tbl[6] = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0};
        tbl[7] = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0};
        tbl[8] = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[9] = '{4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};

        rises    = 0;
        auto_ack = 1'b0;
        rand_ack = 1'b0;
        model_init();
        do_reset();

        for (int r = 0; r < 10; r++) begin
            pulse_in     = tbl[r].pulse;
            xfer_ack     = tbl[r].ack;
            clr_overflow = tbl[r].clr;
            tick();
            chk($sformatf("vec%0d_req", r), 32'(xfer_req), 32'(tbl[r].exp_req));
            chk($sformatf("vec%0d_id", r), 32'(xfer_id), 32'(tbl[r].exp_id));
            chk($sformatf("vec%0d_busy", r), 32'(busy), 32'(tbl[r].exp_busy));
            chk($sformatf("vec%0d_pend", r), 32'(pending_any), 32'(tbl[r].exp_pend));
        end

        // Round-robin from pointer 0, then pointer wraps back to 0 after granting 3.
        do_reset();
        n0 = id_log.size();
        pulse_in = 4'b1101;
        tick();
        drain(200);
        chk("rr_count", 32'(id_log.size() - n0), 32'd3);
        if (id_log.size() - n0 == 3) begin
            chk("rr_first", 32'(id_log[n0]), 32'd0);
            chk("rr_second", 32'(id_log[n0+1]), 32'd2);
            chk("rr_third", 32'(id_log[n0+2]), 32'd3);
        end
        n0 = id_log.size();
        pulse_in = 4'b1001;
        tick();
        drain(200);
        chk("rr_wrap_count", 32'(id_log.size() - n0), 32'd2);
        if (id_log.size() - n0 == 2) begin
            chk("rr_wrap_first", 32'(id_log[n0]), 32'd0);
            chk("rr_wrap_second", 32'(id_log[n0+1]), 32'd3);
        end

        // Three events on requester 1.
        n0 = id_log.size();
        repeat (3) begin
            pulse_in = 4'b0010;
            tick();
        end
        drain(200);
        chk("multi_count", 32'(id_log.size() - n0), 32'd3);
        chk("multi_id1", 32'(count_id(n0, 1)), 32'd3);

        // Saturation: 9 pulses on requester 2 while requester 0 holds the channel.
        auto_ack = 1'b0;
        xfer_ack = 1'b0;
        pulse_in = 4'b0001;
        tick();
        tick();
        chk("sat_channel_held", 32'(xfer_req), 32'd1);
        repeat (9) begin
            pulse_in = 4'b0100;
            tick();
        end
        chk("sat_overflow", 32'(overflow), 32'h4);
        n0 = id_log.size();
        drain(400);
        chk("sat_transfers", 32'(count_id(n0, 2)), 32'd7);
        chk("sat_overflow_sticky", 32'(overflow), 32'h4);
        clr_overflow = 1'b1;
        tick();
        chk("sat_clear", 32'(overflow), 32'h0);

        // Pulse on requester 0 in the very cycle it is granted.
        n0 = id_log.size();
        pulse_in = 4'b0001;
        tick();
        pulse_in = 4'b0001;
        tick();
        chk("gp_req_up", 32'(xfer_req), 32'd1);
        chk("gp_still_pending", 32'(pending_any), 32'd1);
        drain(200);
        chk("gp_transfers", 32'(count_id(n0, 0)), 32'd2);

        // Reset mid-REQ with three events still queued on requester 1.
        auto_ack = 1'b0;
        xfer_ack = 1'b0;
        repeat (4) begin
            pulse_in = 4'b0010;
            tick();
        end
        chk("mid_req_high", 32'(xfer_req), 32'd1);
        chk("mid_count3", 32'(m_cnt[1]), 32'd3);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_req_drop", 32'(xfer_req), 32'd0);
        chk("mid_rst_pending", 32'(pending_any), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk1);
        #1 reset_n = 1'b1;
        model_init();
        n0 = rises;
        auto_ack = 1'b1;
        repeat (30) tick();
        chk("mid_no_transfer", 32'(rises - n0), 32'd0);

        // Randomized traffic against the model.
        do_reset();
        auto_ack = 1'b1;
        rand_ack = 1'b1;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) pulse_in[i] = ($urandom_range(3) == 0);
            clr_overflow = ($urandom_range(15) == 0);
            tick();
        end
        drain(3000);
        for (int i = 0; i < N; i++) chk($sformatf("rand_drained%0d", i), 32'(m_cnt[i]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/f2s_pulse_scheduler.md
Name: f2s_pulse_scheduler

Overview:
- Runs in the fast (clk1) domain and shares one fast-to-slow crossing channel between NUM_REQ pulse requesters.
- Counts incoming single-cycle pulses per requester and grants the channel round-robin.
- Drives each grant as a 4-phase level request with requester ID, so the slow domain never misses a narrow pulse.
- `xfer_ack` is the slow side's acknowledge, already passed through a 2-flop synchronizer into clk1 outside this block.

Parameters:
- NUM_REQ, 4, number of pulse requesters (1..16)
- CNT_W, 3, width of each per-requester pending counter (saturates at 2^CNT_W-1)
- MIN_HOLD, 2, minimum cycles `xfer_req` stays high per transfer (>=1)
- GAP, 2, idle cycles after ack falls before the next grant (0 allowed)
- ID_W, max(1,clog2(NUM_REQ)), width of `xfer_id`

Ports:
- clk1  in  1  fast clock; all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- pulse_in  in  NUM_REQ  per-requester event pulse; each high cycle is one event
- xfer_ack  in  1  synchronized slow-side acknowledge
- clr_overflow  in  1  clears all overflow flags
- xfer_req  out  1  registered request level to slow domain
- xfer_id  out  ID_W  registered ID of granted requester; stable while `xfer_req`=1 and through RELEASE
- pending_any  out  1  OR of all pending counters being non-zero
- overflow  out  NUM_REQ  sticky; set when a pulse arrives at a saturated counter
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE; all counters=0; rr pointer=0; hold and gap counters=0.
  - xfer_req=0, xfer_id=0, overflow=0, busy=0, pending_any=0.
  - Reset mid-transfer drops xfer_req immediately; the in-flight transfer and all pending events are discarded.
- Pending counters, per requester i, every cycle:
  - Increment on pulse_in[i].
  - Decrement when i is granted (IDLE->REQ transition).
  - Both in the same cycle: the counter is unchanged.
  - At max with a pulse and no grant: stays at max and sets overflow[i].
  - Counters never underflow.
- overflow: clr_overflow clears all bits. clr_overflow and a new overflow event in the same cycle: the set wins for that bit.
- Arbiter: round-robin over requesters with count!=0, searching from rr pointer upward with wrap. After granting k, pointer=(k+1) mod NUM_REQ.
- FSM, states IDLE, REQ, RELEASE, GAP:
  - IDLE: if any count!=0, grant k; next cycle xfer_req=1, xfer_id=k, hold counter=1, state=REQ. Otherwise stay.
  - REQ: xfer_req=1. Leave when hold counter>=MIN_HOLD and xfer_ack=1; then xfer_req=0 next cycle and state=RELEASE. Hold counter saturates.
  - RELEASE: xfer_req=0; wait for xfer_ack=0. Then go to GAP with gap counter=GAP, or to IDLE if GAP=0.
  - GAP: decrement each cycle; go to IDLE when it reaches 1.
  - xfer_ack already high on entry to REQ (protocol error): exit still waits for MIN_HOLD; no other special handling.
- Latency:
  - Pulse sampled at edge t with the block in IDLE and all counters zero: counter=1 after t; xfer_req=1 after edge t+1.
  - Back-to-back transfers: minimum period is MIN_HOLD + 1 + GAP cycles plus the ack round-trip.
- pending_any and busy are combinational from registered state.

Decomposition:
- Package f2s_pkg holds:
  - state enum (IDLE, REQ, RELEASE, GAP)
  - clog2 helper function
  - ID_W derivation
- One sub-module: f2s_rr_arbiter. It is combinational; inputs are the request vector and pointer, outputs are grant_valid and grant_id.

Test Plan:
- Single event: pulse_in=0001 for 1 cycle; ack returned 3 cycles after req -> xfer_req rises 2 edges after the pulse, xfer_id=0, req falls the cycle after ack high, GAP=2 idle cycles, busy then 0.
- Round-robin: pulses on req 0, 2 and 3 in the same cycle with immediate ack -> grants in order 0, 2, 3; the next pulse on 0 and 3 together grants 0 (pointer=0 after 3).
- Multiple events, one requester: 3 pulses on req1 -> exactly 3 transfers with xfer_id=1; pending_any=0 after the third grant.
- Saturation: 9 pulses on req2 with CNT_W=3 while a transfer holds the channel -> counter=7, overflow[2]=1, 7 transfers follow; clr_overflow then clears it.
- Simultaneous grant and pulse: req0 count=1, pulse on req0 in the grant cycle -> count stays 1 and a second transfer follows.
- Reset mid-REQ: reset_n low while xfer_req=1 and count=3 -> xfer_req=0 immediately, counters=0, no transfer after release.
